led_pattern_sched: RTL

Priority scheduler for the single status LED on the fall-detection wearable. It arbitrates three requesters: fall alarm, low-battery warning and normal heartbeat. It sequences the matching pattern (fast blink, slow blink, breathing) into a registered PWM duty value and drives the LED pin. It sits between the system-state logic and the board LED and replaces free-running LED drivers.

---
 rtl/led_pattern_sched.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_sched.sv
// ---------------------------------------------------------------------------
// led_pattern_sched
//
// Priority scheduler for the single status LED of the fall-detection
// wearable. Three level requesters compete for the LED: fall alarm
// (highest), low-battery warning, and the normal heartbeat (lowest). The
// winner's pattern is sequenced into a registered PWM duty value. That
// value drives an active-low LED pin.
//
// Patterns:
//   ALARM   : fast blink, FAST_TICKS ticks at full scale, FAST_TICKS at 0
//   WARN    : slow blink, SLOW_TICKS ticks at full scale, SLOW_TICKS at 0
//   BREATHE : triangle 0..FS..0, one duty step per tick, period 2*FS ticks
//   IDLE    : dark
//
// Parameters:
//   CLK_FREQ   - input clock in Hz, only used to derive the TICK_DIV default
//   PWM_WIDTH  - width of the duty value and of the PWM counter
//   TICK_DIV   - clk cycles per pattern tick
//   FAST_TICKS - alarm on/off phase length in ticks
//   SLOW_TICKS - warning on/off phase length in ticks
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   req[2:0]   in   level requests: [2] alarm, [1] warning, [0] heartbeat
//   alarm_ack  in   one-cycle pulse clearing the sticky alarm (latch build)
//   led        out  LED drive, active-low (0 = lit)
//   duty       out  current brightness
//   active_src out  0 none, 1 heartbeat, 2 warning, 3 alarm
//   busy       out  high whenever a pattern is being shown
//
// Build option:
//   LED_ALARM_LATCH_EN - when defined, a rising alarm request sets a sticky
//   latch. The alarm keeps showing after req[2] falls, until alarm_ack.
//   When undefined, the alarm is level-sensitive and alarm_ack is ignored.
// ---------------------------------------------------------------------------
module led_pattern_sched #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int PWM_WIDTH  = 8,
  parameter int TICK_DIV   = CLK_FREQ / 512,
  parameter int FAST_TICKS = 64,
  parameter int SLOW_TICKS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           req,
  input  logic                 alarm_ack,
  output logic                 led,
  output logic [PWM_WIDTH-1:0] duty,
  output logic [1:0]           active_src,
  output logic                 busy
);

  // Full-scale duty and the +1 step constant.
  localparam logic [PWM_WIDTH-1:0] FS      = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] DUTY_ONE = PWM_WIDTH'(1);

  // The tick prescaler is sized from TICK_DIV.
  localparam int             TCW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

  // A single phase counter serves both blink patterns, so size it for the longer one.
  localparam int             MAXPH     = (SLOW_TICKS > FAST_TICKS) ? SLOW_TICKS : FAST_TICKS;
  localparam int             PHW       = (MAXPH > 1) ? $clog2(MAXPH) : 1;
  localparam logic [PHW-1:0] FAST_LAST = PHW'(FAST_TICKS - 1);
  localparam logic [PHW-1:0] SLOW_LAST = PHW'(SLOW_TICKS - 1);

  // Encodings equal the active_src code and the priority order. That
  // allows plain magnitude compares for preemption.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BREATHE = 2'd1,
    S_WARN    = 2'd2,
    S_ALARM   = 2'd3
  } state_t;

  logic [2:0]           r_req;
  logic [TCW-1:0]       r_tick_cnt;
  logic                 w_tick;
  logic                 w_tick_clr;
  logic [PWM_WIDTH-1:0] r_pcnt;
  logic                 r_led;

  state_t               r_state;
  state_t               w_state_nxt;
  state_t               w_winner;
  logic [PWM_WIDTH-1:0] r_duty;
  logic [PWM_WIDTH-1:0] w_duty_nxt;
  logic [PHW-1:0]       r_phase;
  logic [PHW-1:0]       w_phase_nxt;
  logic [PHW-1:0]       w_phase_last;
  logic                 r_on;
  logic                 w_on_nxt;
  logic                 r_dir_up;
  logic                 w_dir_up_nxt;
  logic                 w_enter;
  logic                 w_alarm_req;

  // Input capture, tick prescaler, PWM counter and LED pin register.
  // The prescaler restarts whenever a pattern is entered. The first phase
  // of a newly entered pattern is therefore always a whole number of ticks
  // long, regardless of where the free-running divider happened to be.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req      <= '0;
      r_tick_cnt <= '0;
      r_pcnt     <= '0;
      r_led      <= 1'b1;
    end else begin
      r_req <= req;
      if (w_tick_clr || w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      r_pcnt <= r_pcnt + 1'b1;
      r_led  <= ~(r_pcnt < r_duty);
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

`ifdef LED_ALARM_LATCH_EN
  logic r_req2_d;
  logic r_alarm_latch;
  logic w_alarm_rise;

  // The rising edge counts as an alarm request in the same cycle it is
  // seen. This keeps the alarm at the same two-cycle latency as the other
  // requests. A rise that coincides with an ack keeps the latch set.
  assign w_alarm_rise = r_req[2] & ~r_req2_d;
  assign w_alarm_req  = r_alarm_latch | w_alarm_rise;

  // Sticky alarm latch: set on a rising alarm request, cleared by ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req2_d      <= 1'b0;
      r_alarm_latch <= 1'b0;
    end else begin
      r_req2_d      <= r_req[2];
      r_alarm_latch <= w_alarm_rise | (r_alarm_latch & ~alarm_ack);
    end
  end
`else
  logic w_unused_ack;

  assign w_unused_ack = alarm_ack;
  assign w_alarm_req  = r_req[2];
`endif

  // Highest set request wins. IDLE means nobody is asking.
  always_comb begin
    if (w_alarm_req) begin
      w_winner = S_ALARM;
    end else if (r_req[1]) begin
      w_winner = S_WARN;
    end else if (r_req[0]) begin
      w_winner = S_BREATHE;
    end else begin
      w_winner = S_IDLE;
    end
  end

  // State register, together with the pattern datapath that changes in
  // lock-step with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_duty   <= '0;
      r_phase  <= '0;
      r_on     <= 1'b0;
      r_dir_up <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_duty   <= w_duty_nxt;
      r_phase  <= w_phase_nxt;
      r_on     <= w_on_nxt;
      r_dir_up <= w_dir_up_nxt;
    end
  end

  // Next-state and pattern sequencing.
  // A higher-priority winner preempts immediately. A lower one, or no
  // request, waits for the current pattern's boundary. For a blink, the
  // boundary is the tick that ends the off-phase. For breathing, it is a
  // tick seen while duty is 0. Because preemption is checked first, it
  // wins when it coincides with a boundary. If the winner equals the
  // current state at a boundary, the pattern simply continues without a
  // restart.
  always_comb begin
    w_state_nxt  = r_state;
    w_duty_nxt   = r_duty;
    w_phase_nxt  = r_phase;
    w_on_nxt     = r_on;
    w_dir_up_nxt = r_dir_up;
    w_tick_clr   = 1'b0;
    w_enter      = 1'b0;
    w_phase_last = (r_state == S_ALARM) ? FAST_LAST : SLOW_LAST;

    if (w_winner > r_state) begin
      w_enter = 1'b1;
    end else begin
      case (r_state)
        S_BREATHE: begin
          if (w_tick) begin
            if ((r_duty == '0) && (w_winner != S_BREATHE)) begin
              w_enter = 1'b1;
            end else if (r_dir_up) begin
              // Turn around on reaching full scale, so FS is held for one tick only.
              w_duty_nxt = r_duty + DUTY_ONE;
              if (r_duty == FS - DUTY_ONE) begin
                w_dir_up_nxt = 1'b0;
              end
            end else begin
              w_duty_nxt = r_duty - DUTY_ONE;
              if (r_duty == DUTY_ONE) begin
                w_dir_up_nxt = 1'b1;
              end
            end
          end
        end
        S_WARN, S_ALARM: begin
          if (w_tick) begin
            if (r_phase != w_phase_last) begin
              w_phase_nxt = r_phase + 1'b1;
            end else if (r_on) begin
              w_on_nxt    = 1'b0;
              w_duty_nxt  = '0;
              w_phase_nxt = '0;
            end else if (w_winner != r_state) begin
              w_enter = 1'b1;
            end else begin
              w_on_nxt    = 1'b1;
              w_duty_nxt  = FS;
              w_phase_nxt = '0;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Common entry rules: blinks start lit, breathing starts dark and rising.
    if (w_enter) begin
      w_state_nxt  = w_winner;
      w_phase_nxt  = '0;
      w_on_nxt     = 1'b1;
      w_dir_up_nxt = 1'b1;
      w_tick_clr   = 1'b1;
      w_duty_nxt   = ((w_winner == S_ALARM) || (w_winner == S_WARN)) ? FS : '0;
    end
  end

  // Outputs decoded from the state. Duty and the LED pin come straight
  // from their registers.
  always_comb begin
    active_src = r_state;
    busy       = (r_state != S_IDLE);
  end

  assign duty = r_duty;
  assign led  = r_led;

endmodule
